// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - load-use stall, branch flush and ALU operand forwarding control
// Shadows EX/MEM and MEM/WB destination fields internally and counts stall/flush cycles.
module hazard_fwd_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1_fo,
  input  logic [4:0]       Rs2_fo,
  input  logic [4:0]       Rs1_do,
  input  logic [4:0]       Rs2_do,
  input  logic [4:0]       Rd_do,
  input  logic             Reg_wr_do,
  input  logic             Mem_rd_do,
  input  logic             Branch_taken,
  output logic             Stall,
  output logic             Bubble,
  output logic             Flush_ifid,
  output logic [1:0]       Fwd_a,
  output logic [1:0]       Fwd_b,
  output logic             Hazard_err,
  output logic [CNT_W-1:0] Stall_cnt,
  output logic [CNT_W-1:0] Flush_cnt
);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [4:0]       exm_rd_q, mwb_rd_q;
  logic             exm_wr_q, exm_ld_q, mwb_wr_q;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic exm_hit_a, exm_hit_b, mwb_hit_a, mwb_hit_b;
  logic stall_c, bubble_c, flush_c;

  assign exm_hit_a = exm_wr_q && (exm_rd_q != 5'd0) && (exm_rd_q == Rs1_do);
  assign exm_hit_b = exm_wr_q && (exm_rd_q != 5'd0) && (exm_rd_q == Rs2_do);
  assign mwb_hit_a = mwb_wr_q && (mwb_rd_q != 5'd0) && (mwb_rd_q == Rs1_do);
  assign mwb_hit_b = mwb_wr_q && (mwb_rd_q != 5'd0) && (mwb_rd_q == Rs2_do);

  assign Fwd_a = exm_hit_a ? 2'b10 : (mwb_hit_a ? 2'b01 : 2'b00);
  assign Fwd_b = exm_hit_b ? 2'b10 : (mwb_hit_b ? 2'b01 : 2'b00);

  assign lu = Mem_rd_do && (Rd_do != 5'd0) && ((Rd_do == Rs1_fo) || (Rd_do == Rs2_fo));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    case (state_q)
      RUN: begin
        // A taken branch squashes the dependent instruction anyway, so it beats load-use.
        if (Branch_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = 2'(FLUSH_CYCLES - 1);
          end
        end else if (lu) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end
      end
      FLUSH: begin
        flush_c  = 1'b1;
        bubble_c = 1'b1;
        cnt_d    = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Gating by reset makes controls drop the instant reset asserts, regardless of inputs.
  assign Stall      = stall_c  & reset;
  assign Bubble     = bubble_c & reset;
  assign Flush_ifid = flush_c  & reset;

  assign err_d       = err_q | (exm_ld_q & (exm_hit_a | exm_hit_b));
  assign stall_cnt_d = (stall_c && (stall_cnt_q != {CNT_W{1'b1}}))
                       ? stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : stall_cnt_q;
  assign flush_cnt_d = (flush_c && (flush_cnt_q != {CNT_W{1'b1}}))
                       ? flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : flush_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      cnt_q       <= 2'd0;
      exm_rd_q    <= 5'd0;
      exm_wr_q    <= 1'b0;
      exm_ld_q    <= 1'b0;
      mwb_rd_q    <= 5'd0;
      mwb_wr_q    <= 1'b0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      exm_rd_q    <= Rd_do;
      exm_wr_q    <= Reg_wr_do;
      exm_ld_q    <= Mem_rd_do;
      mwb_rd_q    <= exm_rd_q;
      mwb_wr_q    <= exm_wr_q;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Hazard_err = err_q;
  assign Stall_cnt  = stall_cnt_q;
  assign Flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - vector table, corner sequences and randomized model check
// Reference model tracks the last two ID/EX records and a remaining-flush count.
module tb_hazard_fwd_unit;
  localparam int FC = 2;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] Rs1_fo, Rs2_fo, Rs1_do, Rs2_do, Rd_do;
  logic Reg_wr_do, Mem_rd_do, Branch_taken;
  logic Stall, Bubble, Flush_ifid, Hazard_err;
  logic [1:0] Fwd_a, Fwd_b;
  logic [CW-1:0] Stall_cnt, Flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .Rs1_fo(Rs1_fo), .Rs2_fo(Rs2_fo), .Rs1_do(Rs1_do), .Rs2_do(Rs2_do), .Rd_do(Rd_do),
    .Reg_wr_do(Reg_wr_do), .Mem_rd_do(Mem_rd_do), .Branch_taken(Branch_taken),
    .Stall(Stall), .Bubble(Bubble), .Flush_ifid(Flush_ifid),
    .Fwd_a(Fwd_a), .Fwd_b(Fwd_b), .Hazard_err(Hazard_err),
    .Stall_cnt(Stall_cnt), .Flush_cnt(Flush_cnt)
  );

  typedef struct {
    logic [4:0] rs1f, rs2f, rs1d, rs2d, rd;
    logic wr, ld, br;
    logic st, bu, fl;
    logic [1:0] fa, fb;
    int sc, fcn;
  } vec_t;

  typedef struct {
    logic [4:0] rd;
    logic wr, ld;
  } stg_t;

  vec_t vt[21];
  stg_t hist[$];
  int flush_left, m_sc, m_fc;
  bit m_err;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(int rs1f, int rs2f, int rs1d, int rs2d, int rd, int wr, int ld,
                              int br, int st, int bu, int fl, int fa, int fb, int sc, int fcn);
    vec_t v;
    v.rs1f = 5'(rs1f); v.rs2f = 5'(rs2f); v.rs1d = 5'(rs1d); v.rs2d = 5'(rs2d); v.rd = 5'(rd);
    v.wr = 1'(wr); v.ld = 1'(ld); v.br = 1'(br);
    v.st = 1'(st); v.bu = 1'(bu); v.fl = 1'(fl); v.fa = 2'(fa); v.fb = 2'(fb);
    v.sc = sc; v.fcn = fcn;
    return v;
  endfunction

  task automatic set_in(int rs1f, int rs2f, int rs1d, int rs2d, int rd, int wr, int ld, int br);
    Rs1_fo = 5'(rs1f); Rs2_fo = 5'(rs2f); Rs1_do = 5'(rs1d); Rs2_do = 5'(rs2d); Rd_do = 5'(rd);
    Reg_wr_do = 1'(wr); Mem_rd_do = 1'(ld); Branch_taken = 1'(br);
  endtask

  function automatic int m_fwd(logic [4:0] rs);
    if (hist[0].wr && hist[0].rd != 0 && hist[0].rd == rs) return 2;
    if (hist[1].wr && hist[1].rd != 0 && hist[1].rd == rs) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    stg_t z;
    z.rd = 5'd0; z.wr = 1'b0; z.ld = 1'b0;
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
    flush_left = 0; m_sc = 0; m_fc = 0; m_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // cycle-by-cycle program from reset with FLUSH_CYCLES = 2
    vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    vt[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    vt[3]  = mk(0, 0, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    vt[4]  = mk(0, 0, 5, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0, 0, 0);
    vt[5]  = mk(0, 0, 5, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    vt[6]  = mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    vt[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    vt[8]  = mk(0, 0, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    vt[9]  = mk(0, 0, 0, 3, 3, 1, 0, 0,  0, 0, 0, 0, 2, 0, 0);
    vt[10] = mk(0, 0, 0, 3, 0, 0, 0, 0,  0, 0, 0, 0, 2, 0, 0);
    vt[11] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    vt[12] = mk(0, 7, 0, 0, 7, 1, 1, 0,  1, 1, 0, 0, 0, 1, 0);
    vt[13] = mk(0, 7, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0);
    vt[14] = mk(0, 0, 0, 7, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0);
    vt[15] = mk(4, 0, 0, 0, 4, 1, 1, 1,  0, 1, 1, 0, 0, 1, 1);
    vt[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 1, 2);
    vt[17] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 2);
    vt[18] = mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 1, 3);
    vt[19] = mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 1, 4);
    vt[20] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 4);

    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("rst_stall", Stall, 0);
    chk("rst_bubble", Bubble, 0);
    chk("rst_flush", Flush_ifid, 0);
    chk("rst_fwd_a", Fwd_a, 0);
    chk("rst_fwd_b", Fwd_b, 0);
    do_reset();
    chk("rst_scnt", Stall_cnt, 0);
    chk("rst_fcnt", Flush_cnt, 0);
    chk("rst_err", Hazard_err, 0);

    for (int i = 0; i < 21; i++) begin
      set_in(vt[i].rs1f, vt[i].rs2f, vt[i].rs1d, vt[i].rs2d, vt[i].rd,
             vt[i].wr, vt[i].ld, vt[i].br);
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), Stall, vt[i].st);
      chk($sformatf("v%0d_bubble", i), Bubble, vt[i].bu);
      chk($sformatf("v%0d_flush", i), Flush_ifid, vt[i].fl);
      chk($sformatf("v%0d_fwd_a", i), Fwd_a, vt[i].fa);
      chk($sformatf("v%0d_fwd_b", i), Fwd_b, vt[i].fb);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_scnt", i), Stall_cnt, vt[i].sc);
      chk($sformatf("v%0d_fcnt", i), Flush_cnt, vt[i].fcn);
      chk($sformatf("v%0d_err", i), Hazard_err, 0);
    end

    // forwarding from a load that is still in EX/MEM
    set_in(0, 0, 0, 0, 7, 1, 1, 0);
    @(posedge clk); #1;
    set_in(0, 0, 7, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lderr_fwd_a", Fwd_a, 2);
    chk("lderr_pre", Hazard_err, 0);
    @(posedge clk); #1;
    chk("lderr_set", Hazard_err, 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("lderr_sticky", Hazard_err, 1);

    // continuous load-use to drive the stall counter into saturation
    set_in(0, 7, 0, 0, 7, 1, 1, 0);
    repeat (252) @(posedge clk);
    #1;
    chk("sat_below", Stall_cnt, 253);
    @(negedge clk);
    chk("sat_stall", Stall, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_hold", Stall_cnt, CMAX);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("sat_idle", Stall_cnt, CMAX);

    // reset asserted while flushing
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rf_flushing", Flush_ifid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rf_flush", Flush_ifid, 0);
    chk("rf_bubble", Bubble, 0);
    chk("rf_stall", Stall, 0);
    chk("rf_scnt", Stall_cnt, 0);
    chk("rf_err", Hazard_err, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int e_st, e_bu, e_fl, lu;
      stg_t s;
      set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      @(negedge clk);
      lu = (Mem_rd_do && Rd_do != 0 && (Rd_do == Rs1_fo || Rd_do == Rs2_fo)) ? 1 : 0;
      e_st = 0; e_bu = 0; e_fl = 0;
      if (flush_left > 0) begin
        e_fl = 1; e_bu = 1; flush_left--;
      end else if (Branch_taken) begin
        e_fl = 1; e_bu = 1; flush_left = FC - 1;
      end else if (lu != 0) begin
        e_st = 1; e_bu = 1;
      end
      chk("rnd_stall", Stall, e_st);
      chk("rnd_bubble", Bubble, e_bu);
      chk("rnd_flush", Flush_ifid, e_fl);
      chk("rnd_fwd_a", Fwd_a, m_fwd(Rs1_do));
      chk("rnd_fwd_b", Fwd_b, m_fwd(Rs2_do));
      if (m_fwd(Rs1_do) == 2 || m_fwd(Rs2_do) == 2) if (hist[0].ld) m_err = 1'b1;
      if (e_st != 0 && m_sc < CMAX) m_sc++;
      if (e_fl != 0 && m_fc < CMAX) m_fc++;
      s.rd = Rd_do; s.wr = Reg_wr_do; s.ld = Mem_rd_do;
      hist.push_front(s);
      void'(hist.pop_back());
      @(posedge clk); #1;
      chk("rnd_scnt", Stall_cnt, m_sc);
      chk("rnd_fcnt", Flush_cnt, m_fc);
      chk("rnd_err", Hazard_err, int'(m_err));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Pipeline hazard controller that reads the ID/EX register outputs and the IF/ID register fields. It drives the stall, bubble and flush controls back into the IF/ID and ID/EX registers, and the ALU operand forwarding selects in EX. It keeps its own shadow copy of the EX/MEM and MEM/WB destination fields, so no extra pipeline-register ports are needed. It also keeps saturating performance counters for stalls and flushes.

Parameters:
FLUSH_CYCLES, 2, number of cycles IF/ID and ID/EX are flushed after a taken branch/jump (1..3)
CNT_W, 16, width of stall/flush performance counters

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset
Rs1_fo  in  5  rs1 of instruction currently in IF/ID (decode)
Rs2_fo  in  5  rs2 of instruction currently in IF/ID
Rs1_do  in  5  rs1 held in ID/EX
Rs2_do  in  5  rs2 held in ID/EX
Rd_do  in  5  rd held in ID/EX
Reg_wr_do  in  1  ID/EX register-write control
Mem_rd_do  in  1  ID/EX load control
Branch_taken  in  1  taken branch/jump resolved in EX this cycle
Stall  out  1  hold PC and IF/ID (write-enable low)
Bubble  out  1  zero all control inputs into ID/EX this edge
Flush_ifid  out  1  replace IF/ID contents with NOP this edge
Fwd_a  out  2  ALU operand A select: 00 Read_data1_do, 10 EX/MEM result, 01 MEM/WB write data
Fwd_b  out  2  same encoding for operand B
Hazard_err  out  1  sticky: forward requested from a load still in EX/MEM
Stall_cnt  out  CNT_W  saturating count of load-use stall cycles
Flush_cnt  out  CNT_W  saturating count of flush cycles

Behaviour:
- Reset (reset==0, async): shadow regs exm_{rd,wr,ld} and mwb_{rd,wr} cleared; state RUN; flush counter 0; Hazard_err, Stall_cnt, Flush_cnt = 0. With reset low and inputs 0, the combinational outputs Stall, Bubble, Flush_ifid, Fwd_a and Fwd_b are all 0.
- Shadow pipeline, every posedge:
  - exm <= {Rd_do, Reg_wr_do, Mem_rd_do}; mwb <= {exm_rd, exm_wr}.
  - When Bubble or flush is active this cycle, exm is still loaded from the ID/EX outputs. Those already hold the inserted bubble, i.e. Reg_wr_do = 0.
- Forwarding (combinational, same cycle):
  - Fwd_a = 10 if exm_wr && exm_rd != 0 && exm_rd == Rs1_do.
  - Otherwise Fwd_a = 01 if mwb_wr && mwb_rd != 0 && mwb_rd == Rs1_do.
  - Otherwise Fwd_a = 00.
  - Fwd_b uses the same rules with Rs2_do.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Hazard_err: set on a posedge if the 10 condition holds with exm_ld = 1. Cleared only by reset.
- Load-use detection (combinational): lu = Mem_rd_do && Rd_do != 0 && (Rd_do == Rs1_fo || Rd_do == Rs2_fo).
- FSM states: RUN, FLUSH.
  - RUN, Branch_taken = 1: Flush_ifid = 1 and Bubble = 1 this cycle. lu is ignored, so Stall = 0 and the branch wins. Next state FLUSH with cnt = FLUSH_CYCLES-1. If FLUSH_CYCLES == 1, stay in RUN.
  - RUN, lu = 1 and no branch: Stall = 1 and Bubble = 1 for exactly one cycle. The next cycle ID/EX holds the bubble, so lu falls naturally. Load-use latency is a 1-cycle penalty.
  - FLUSH: Flush_ifid = 1, Bubble = 1, Stall = 0. cnt decrements each cycle; return to RUN when cnt reaches 0 on that edge.
  - FLUSH with Branch_taken = 1: ignored, since EX holds a bubble and a branch cannot be valid.
- Counters: Stall_cnt +1 on each posedge with Stall = 1. Flush_cnt +1 on each posedge with Flush_ifid = 1. Both saturate at all-ones with no wrap.
- Reset asserted mid-flush or mid-stall: returns to RUN immediately and all controls drop asynchronously.

Test Plan:
- Reset, then 3 idle cycles -> Stall = Bubble = Flush_ifid = 0, Fwd_a = Fwd_b = 00, counters 0.
- ALU producer x5 (Rd_do = 5, Reg_wr_do = 1), next cycle Rs1_do = 5 with exm_rd = 5 -> Fwd_a = 10. One cycle later, with x5 only in MEM/WB -> Fwd_a = 01. Same test with Rd = 0 -> Fwd_a = 00.
- x3 written in both EX/MEM and MEM/WB, Rs2_do = 3 -> Fwd_b = 10 (priority).
- Load Rd_do = 7, Mem_rd_do = 1, Rs2_fo = 7 -> Stall = Bubble = 1 for exactly 1 cycle. The following cycle Fwd_b = 01, Stall_cnt = 1, Hazard_err = 0.
- Branch_taken pulse with FLUSH_CYCLES = 2 -> Flush_ifid = Bubble = 1 for 2 cycles, then 0, Flush_cnt = 2. Branch coincident with lu -> Stall = 0.
- Force Stall_cnt near all-ones plus 3 stalls -> counter holds at all-ones. Reset pulse during FLUSH -> outputs 0 before the next clock edge.
